// File: rtl/seq_shift_add_mult.sv
// Sequential radix-2 shift-and-add multiplier with signed/unsigned modes and a start/busy/done handshake.
// Optional build macro SEQ_MULT_EARLY_TERM_EN: leave RUN once the remaining multiplier bits are zero.
module seq_shift_add_mult #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [PW-1:0]    acc_q;
  logic             neg_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_d;
  logic             done_d;

  logic             sa_c;
  logic             sb_c;
  logic [WIDTH-1:0] mag_a_c;
  logic [WIDTH-1:0] mag_b_c;
  logic [WIDTH:0]   sum_c;
  logic [PW-1:0]    acc_iter_c;
  logic [PW-1:0]    acc_run_c;
  logic [WIDTH-1:0] mplier_iter_c;
  logic [CNT_W-1:0] cnt_inc_c;
  logic             last_c;

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    sa_c    = signed_mode & op_a[WIDTH-1];
    sb_c    = signed_mode & op_b[WIDTH-1];
    mag_a_c = sa_c ? (WIDTH'(0) - op_a) : op_a;
    mag_b_c = sb_c ? (WIDTH'(0) - op_b) : op_b;
  end

  // One radix-2 iteration: conditional add into the upper half, then shift right with carry in the MSB.
  always_comb begin
    sum_c         = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, mcand_q};
    acc_iter_c    = mplier_q[0] ? {sum_c, acc_q[WIDTH-1:1]} : {1'b0, acc_q[PW-1:1]};
    mplier_iter_c = {1'b0, mplier_q[WIDTH-1:1]};
    cnt_inc_c     = cnt_q + CNT_W'(1);
  end

`ifdef SEQ_MULT_EARLY_TERM_EN
  // Early exit right-aligns the partial sum by the iterations that were skipped.
  always_comb begin
    last_c    = (cnt_inc_c == CNT_W'(WIDTH)) || (mplier_iter_c == '0);
    acc_run_c = acc_iter_c >> (CNT_W'(WIDTH) - cnt_inc_c);
  end
`else
  always_comb begin
    last_c    = (cnt_inc_c == CNT_W'(WIDTH));
    acc_run_c = acc_iter_c;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last_c) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN) || (state_d == ST_DONE);
    done_d = (state_q == ST_DONE);
  end

  // Datapath and registered outputs; product only moves on the DONE edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
    end else begin
      busy <= busy_d;
      done <= done_d;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            mcand_q  <= mag_a_c;
            mplier_q <= mag_b_c;
            neg_q    <= sa_c ^ sb_c;
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        ST_RUN: begin
          acc_q    <= acc_run_c;
          mplier_q <= mplier_iter_c;
          cnt_q    <= cnt_inc_c;
        end
        ST_DONE: begin
          product <= neg_q ? (PW'(0) - acc_q) : acc_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Self-checking bench for seq_shift_add_mult: WIDTH=8 and WIDTH=32 instances against an arithmetic reference.
module tb_seq_shift_add_mult;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        start32, sm32, busy32, done32;
  logic [31:0] a32, b32;
  logic [63:0] p32;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_shift_add_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .signed_mode(sm8),
    .op_a(a8), .op_b(b8), .busy(busy8), .done(done8), .product(p8)
  );

  seq_shift_add_mult #(.WIDTH(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .start(start32), .signed_mode(sm32),
    .op_a(a32), .op_b(b32), .busy(busy32), .done(done32), .product(p32)
  );

  // Reference product: sign-extend (or zero-extend) to 64 bits, multiply, keep 2*w bits.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input bit sm, input int w);
    logic [63:0] am, bm, mask;
    longint va, vb;
    am   = 64'(a) & ((64'd1 << w) - 64'd1);
    bm   = 64'(b) & ((64'd1 << w) - 64'd1);
    mask = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    va   = (sm && am[w-1]) ? longint'(am) - longint'(64'd1 << w) : longint'(am);
    vb   = (sm && bm[w-1]) ? longint'(bm) - longint'(64'd1 << w) : longint'(bm);
    return 64'(va * vb) & mask;
  endfunction

  // Cycles from the accepting edge to the cycle in which done is seen: RUN cycles + 1.
  function automatic int exp_lat(input logic [31:0] b, input bit sm, input int w);
    int run;
`ifdef SEQ_MULT_EARLY_TERM_EN
    logic [63:0] bm;
    bm = 64'(b) & ((64'd1 << w) - 64'd1);
    if (sm && bm[w-1]) bm = (64'd1 << w) - bm;
    run = 1;
    for (int i = 0; i < w; i++) if (bm[i]) run = i + 1;
`else
    run = w;
`endif
    return run + 1;
  endfunction

  function automatic logic [63:0] cur_prod(input int w);
    return (w == 8) ? {48'd0, p8} : p32;
  endfunction

  // Issue one op from IDLE and wait (bounded) for done; returns in the done cycle.
  task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b, input bit sm,
                        output int lat, output logic [63:0] p, output bit stable, output bit busy_ok);
    logic [63:0] prev;
    prev = cur_prod(w);
    if (w == 8) begin a8 = a[7:0]; b8 = b[7:0]; sm8 = sm; start8 = 1'b1; end
    else begin a32 = a; b32 = b; sm32 = sm; start32 = 1'b1; end
    @(negedge clk);
    start8 = 1'b0; start32 = 1'b0;
    lat = 0; stable = 1'b1; busy_ok = 1'b1;
    while (!((w == 8) ? done8 : done32) && lat < 200) begin
      if (cur_prod(w) != prev) stable = 1'b0;
      if (!((w == 8) ? busy8 : busy32)) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    p = cur_prod(w);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    start32 = 1'b0; sm32 = 1'b0; a32 = '0; b32 = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy8 got=%b exp=0", busy8); end
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done8 got=%b exp=0", done8); end
    checks++; if (p8 !== 16'h0) begin errors++; $display("FAIL reset_prod8 got=%h exp=0", p8); end
    checks++; if (busy32 !== 1'b0 || done32 !== 1'b0) begin errors++; $display("FAIL reset_ctl32 got=%b%b exp=00", busy32, done32); end
    checks++; if (p32 !== 64'h0) begin errors++; $display("FAIL reset_prod32 got=%h exp=0", p32); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned_max;
    int lat; logic [63:0] p; bit st, bo;
    run_op(8, 32'hFF, 32'hFF, 1'b0, lat, p, st, bo);
    checks++; if (lat != 9) begin errors++; $display("FAIL umax_latency got=%0d exp=9", lat); end
    checks++; if (p !== 64'hFE01) begin errors++; $display("FAIL umax_product got=%h exp=fe01", p); end
    checks++; if (!bo) begin errors++; $display("FAIL umax_busy_run got=0 exp=1"); end
    checks++; if (!st) begin errors++; $display("FAIL umax_prod_stable got=changed exp=held"); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL umax_busy_at_done got=%b exp=0", busy8); end
    @(negedge clk);
    checks++; if (done8 !== 1'b0 || busy8 !== 1'b0) begin errors++; $display("FAIL umax_after got=%b%b exp=00", done8, busy8); end
    checks++; if (p8 !== 16'hFE01) begin errors++; $display("FAIL umax_hold got=%h exp=fe01", p8); end
  endtask

  task automatic test_signed;
    logic [7:0]  ta [3] = '{8'h80, 8'hFF, 8'h05};
    logic [7:0]  tb [3] = '{8'h80, 8'h01, 8'hFD};
    logic [15:0] tp [3] = '{16'h4000, 16'hFFFF, 16'hFFF1};
    int lat; logic [63:0] p; bit st, bo;
    for (int i = 0; i < 3; i++) begin
      run_op(8, 32'(ta[i]), 32'(tb[i]), 1'b1, lat, p, st, bo);
      checks++; if (p !== 64'(tp[i])) begin errors++; $display("FAIL signed_%0d got=%h exp=%h", i, p, tp[i]); end
      checks++; if (lat != exp_lat(32'(tb[i]), 1'b1, 8)) begin errors++; $display("FAIL signed_lat_%0d got=%0d exp=%0d", i, lat, exp_lat(32'(tb[i]), 1'b1, 8)); end
      @(negedge clk);
    end
  endtask

  task automatic test_zero;
    int lat; logic [63:0] p; bit st, bo;
    for (int m = 0; m < 2; m++) begin
      run_op(8, 32'h00, 32'hA5, m[0], lat, p, st, bo);
      checks++; if (p !== 64'h0) begin errors++; $display("FAIL zero_m%0d got=%h exp=0", m, p); end
      checks++; if (done8 !== 1'b1) begin errors++; $display("FAIL zero_done_m%0d got=%b exp=1", m, done8); end
      checks++; if (!st) begin errors++; $display("FAIL zero_stable_m%0d got=changed exp=held", m); end
      @(negedge clk);
      checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL zero_pulse_m%0d got=%b exp=0", m, done8); end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [63:0] e1, e2;
    e1 = ref_prod(32'h12, 32'h34, 1'b0, 8);
    e2 = ref_prod(32'h77, 32'h09, 1'b1, 8);
    a8 = 8'h12; b8 = 8'h34; sm8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    lat = 0;
    while (!done8 && lat < 200) begin
      if (lat == 3) begin a8 = 8'h77; b8 = 8'h09; sm8 = 1'b1; end
      @(negedge clk);
      lat++;
    end
    checks++; if (p8 !== e1[15:0]) begin errors++; $display("FAIL b2b_first got=%h exp=%h", p8, e1[15:0]); end
    checks++; if (lat != exp_lat(32'h34, 1'b0, 8)) begin errors++; $display("FAIL b2b_first_lat got=%0d exp=%0d", lat, exp_lat(32'h34, 1'b0, 8)); end
    @(negedge clk);
    start8 = 1'b0;
    checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL b2b_second_accept got=%b exp=1", busy8); end
    lat = 0;
    while (!done8 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (p8 !== e2[15:0]) begin errors++; $display("FAIL b2b_second got=%h exp=%h", p8, e2[15:0]); end
    checks++; if (lat != exp_lat(32'h09, 1'b1, 8)) begin errors++; $display("FAIL b2b_second_lat got=%0d exp=%0d", lat, exp_lat(32'h09, 1'b1, 8)); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int lat; logic [63:0] p, e; bit st, bo, seen;
    run_op(8, 32'h0F, 32'h0F, 1'b0, lat, p, st, bo);
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h44; sm8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if (p8 !== 16'h0) begin errors++; $display("FAIL rstmid_prod got=%h exp=0", p8); end
    checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin errors++; $display("FAIL rstmid_ctl got=%b%b exp=00", busy8, done8); end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done8 !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL rstmid_no_done got=pulse exp=none"); end
    e = ref_prod(32'hC3, 32'h5A, 1'b1, 8);
    run_op(8, 32'hC3, 32'h5A, 1'b1, lat, p, st, bo);
    checks++; if (p !== e) begin errors++; $display("FAIL rstmid_next got=%h exp=%h", p, e); end
    @(negedge clk);
  endtask

  task automatic test_early;
    int lat; logic [63:0] p; bit st, bo;
    run_op(8, 32'h03, 32'h02, 1'b0, lat, p, st, bo);
    checks++; if (p !== 64'h6) begin errors++; $display("FAIL early_3x2 got=%h exp=6", p); end
`ifdef SEQ_MULT_EARLY_TERM_EN
    checks++; if (lat != 3) begin errors++; $display("FAIL early_3x2_lat got=%0d exp=3", lat); end
`else
    checks++; if (lat != 9) begin errors++; $display("FAIL early_3x2_lat got=%0d exp=9", lat); end
`endif
    @(negedge clk);
    run_op(8, 32'h01, 32'h80, 1'b0, lat, p, st, bo);
    checks++; if (lat != 9) begin errors++; $display("FAIL early_b80_lat got=%0d exp=9", lat); end
    checks++; if (p !== 64'h80) begin errors++; $display("FAIL early_b80 got=%h exp=80", p); end
    @(negedge clk);
  endtask

  task automatic test_random(input int w, input int n);
    int lat; logic [63:0] p, e; bit st, bo, sm;
    logic [31:0] a, b;
    for (int i = 0; i < n; i++) begin
      a  = $urandom;
      sm = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0:       b = 32'($urandom_range(0, 255));
        1:       b = (w == 8) ? 32'h80 : 32'h8000_0000;
        2:       b = '0;
        default: b = $urandom;
      endcase
      if (w == 8) begin a = a & 32'hFF; b = b & 32'hFF; end
      e = ref_prod(a, b, sm, w);
      run_op(w, a, b, sm, lat, p, st, bo);
      checks++; if (p !== e) begin errors++; $display("FAIL rand%0d_prod a=%h b=%h s=%0d got=%h exp=%h", w, a, b, sm, p, e); end
      checks++; if (lat != exp_lat(b, sm, w)) begin errors++; $display("FAIL rand%0d_lat b=%h s=%0d got=%0d exp=%0d", w, b, sm, lat, exp_lat(b, sm, w)); end
      checks++; if (!st || !bo) begin errors++; $display("FAIL rand%0d_hs stable=%0d busy=%0d exp=1 1", w, st, bo); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed();
    test_zero();
    test_back_to_back();
    test_reset_mid();
    test_early();
    test_random(8, 24);
    test_random(32, 24);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
